// File: rtl/aes_pkg.sv
// Shared AES-128 constants: key-schedule widths, FSM encodings, S-box and round-constant tables.
package aes_pkg;

  localparam int unsigned AES_KW = 128;
  localparam int unsigned AES_NR = 10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    DONE   = 2'd2
  } ks_state_e;

  localparam logic [7:0] AES_RCON [1:10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  // Byte 0x00 occupies bits 0..7, byte 0xff occupies bits 2040..2047.
  localparam logic [0:2047] AES_SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] aes_sbox(input logic [7:0] b);
    return AES_SBOX[{b, 3'b000} +: 8];
  endfunction

  // Out-of-table rounds map to zero so a stray index can never alias a real constant.
  function automatic logic [7:0] aes_rcon(input logic [3:0] r);
    if (r >= 4'd1 && r <= 4'd10) begin
      return AES_RCON[r];
    end
    return 8'h00;
  endfunction

endpackage

// File: rtl/key_expansion.sv
// Combinational AES-128 key-expansion step: derives round key r from round key r-1.
module key_expansion
  import aes_pkg::*;
(
  input  logic [0:127] wIn,
  input  logic [3:0]   roundNum,
  output logic [0:127] wOut
);

  logic [0:31] w0, w1, w2, w3;
  logic [0:31] rot, sub, temp;
  logic [0:31] n0, n1, n2, n3;

  always_comb begin
    w0   = wIn[0:31];
    w1   = wIn[32:63];
    w2   = wIn[64:95];
    w3   = wIn[96:127];
    rot  = {w3[8:31], w3[0:7]};
    sub  = {aes_sbox(rot[0:7]), aes_sbox(rot[8:15]), aes_sbox(rot[16:23]),
            aes_sbox(rot[24:31])};
    temp = sub ^ {aes_rcon(roundNum), 24'h000000};
    n0   = w0 ^ temp;
    n1   = w1 ^ n0;
    n2   = w2 ^ n1;
    n3   = w3 ^ n2;
    wOut = {n0, n1, n2, n3};
  end

endmodule

// File: rtl/key_schedule_ctrl.sv
// Sequential AES-128 key schedule: one expansion round per clock, all round keys held in a
// register file with a combinational random-access read port.
module key_schedule_ctrl
  import aes_pkg::*;
#(
  parameter int unsigned NR = AES_NR,
  parameter int unsigned KW = AES_KW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          key_valid,
  input  logic [0:KW-1] key_in,
  output logic          key_ready,
  input  logic [0:3]    rk_idx,
  output logic [0:KW-1] rk_out,
  output logic          keys_valid,
  output logic          busy
);

  localparam logic [3:0] NrL = 4'(NR);

  ks_state_e     state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [0:KW-1] rk_q [0:NR];
  logic [0:KW-1] rk_d [0:NR];

  logic          we;
  logic [3:0]    waddr;
  logic [0:KW-1] wdata;
  logic [0:127]  exp_in;
  logic [0:127]  exp_out;
  logic [3:0]    round_num;

  // Outside EXPAND the stage input is parked so the round constant never sees 0.
  always_comb begin
    exp_in    = '0;
    round_num = 4'd1;
    if (state_q == EXPAND) begin
      exp_in    = rk_q[cnt_q - 4'd1];
      round_num = cnt_q;
    end
  end

  key_expansion u_key_expansion (
    .wIn      (exp_in),
    .roundNum (round_num),
    .wOut     (exp_out)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we      = 1'b0;
    waddr   = 4'd0;
    wdata   = '0;
    unique case (state_q)
      IDLE, DONE: begin
        if (key_valid) begin
          we      = 1'b1;
          waddr   = 4'd0;
          wdata   = key_in;
          cnt_d   = 4'd1;
          state_d = EXPAND;
        end
      end
      EXPAND: begin
        we    = 1'b1;
        waddr = cnt_q;
        wdata = exp_out;
        // Counter holds at NR on exit rather than running past the table.
        if (cnt_q == NrL) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rk_d = rk_q;
    if (we) begin
      rk_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      for (int unsigned i = 0; i <= NR; i++) begin
        rk_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rk_q    <= rk_d;
    end
  end

  always_comb begin
    rk_out = '0;
    if (rk_idx <= NrL) begin
      rk_out = rk_q[rk_idx];
    end
  end

  assign key_ready  = (state_q != EXPAND);
  assign busy       = (state_q == EXPAND);
  assign keys_valid = (state_q == DONE);

endmodule

// File: tb/tb_key_schedule_ctrl.sv
// Directed bench for key_schedule_ctrl using FIPS-197 key-expansion vectors.
module tb_key_schedule_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         key_valid;
  logic [0:127] key_in;
  logic         key_ready;
  logic [0:3]   rk_idx;
  logic [0:127] rk_out;
  logic         keys_valid;
  logic         busy;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [127:0] KeyF  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KeyZ  = 128'h0;
  localparam logic [127:0] F1    = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] F2    = 128'hf2c295f27a96b9435935807a7359f67f;
  localparam logic [127:0] F9    = 128'hac7766f319fadc2128d12941575c006e;
  localparam logic [127:0] F10   = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] Z1    = 128'h62636363626363636263636362636363;
  localparam logic [127:0] Z2    = 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa;
  localparam logic [127:0] Z10   = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  typedef struct {
    logic [127:0] key;
    logic [3:0]   idx;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs [14];

  key_schedule_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .key_valid  (key_valid),
    .key_in     (key_in),
    .key_ready  (key_ready),
    .rk_idx     (rk_idx),
    .rk_out     (rk_out),
    .keys_valid (keys_valid),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_chk(input string name, input logic [3:0] idx, input logic [127:0] exp);
    rk_idx = idx;
    #1;
    chk(name, rk_out, exp);
  endtask

  // Presents a key for exactly one accepting edge.
  task automatic load_key(input logic [127:0] k);
    int guard = 0;
    while (!key_ready && guard < 30) begin
      tick();
      guard++;
    end
    chk("load_ready", {127'h0, key_ready}, 128'h1);
    key_valid = 1'b1;
    key_in    = k;
    tick();
    key_valid = 1'b0;
  endtask

  // Counts edges after the accepting edge until keys_valid rises; expected 10 for NR=10.
  task automatic wait_done(input string name);
    int n = 0;
    while (!keys_valid && n < 30) begin
      tick();
      n++;
    end
    chk(name, 128'(n), 128'd10);
  endtask

  initial begin
    int acc_edges [$];
    vecs[0]  = '{KeyF, 4'd0,  KeyF};
    vecs[1]  = '{KeyF, 4'd1,  F1};
    vecs[2]  = '{KeyF, 4'd2,  F2};
    vecs[3]  = '{KeyF, 4'd9,  F9};
    vecs[4]  = '{KeyF, 4'd10, F10};
    vecs[5]  = '{KeyF, 4'd11, 128'h0};
    vecs[6]  = '{KeyF, 4'd15, 128'h0};
    vecs[7]  = '{KeyZ, 4'd0,  KeyZ};
    vecs[8]  = '{KeyZ, 4'd1,  Z1};
    vecs[9]  = '{KeyZ, 4'd2,  Z2};
    vecs[10] = '{KeyZ, 4'd10, Z10};
    vecs[11] = '{KeyZ, 4'd12, 128'h0};
    vecs[12] = '{KeyF, 4'd1,  F1};
    vecs[13] = '{KeyF, 4'd10, F10};

    rst = 1'b1; key_valid = 1'b0; key_in = '0; rk_idx = '0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_key_ready", {127'h0, key_ready}, 128'h1);
    chk("rst_busy", {127'h0, busy}, 128'h0);
    chk("rst_keys_valid", {127'h0, keys_valid}, 128'h0);
    read_chk("rst_rk0", 4'd0, 128'h0);

    // Table: reload whenever the record's key differs from what is loaded.
    for (int i = 0; i < 14; i++) begin
      if (i == 0 || vecs[i].key !== vecs[i-1].key) begin
        load_key(vecs[i].key);
        chk("accept_busy", {127'h0, busy}, 128'h1);
        chk("accept_ready", {127'h0, key_ready}, 128'h0);
        chk("accept_kv", {127'h0, keys_valid}, 128'h0);
        wait_done("latency");
      end
      read_chk($sformatf("vec%0d_idx%0d", i, vecs[i].idx), vecs[i].idx, vecs[i].exp);
    end

    // key_valid with a different key during EXPAND must be ignored.
    load_key(KeyF);
    for (int k = 1; k <= 10; k++) begin
      key_valid = (k >= 3 && k <= 5);
      key_in    = KeyZ;
      chk($sformatf("ign_ready_%0d", k), {127'h0, key_ready}, 128'h0);
      tick();
    end
    key_valid = 1'b0;
    chk("ign_kv", {127'h0, keys_valid}, 128'h1);
    read_chk("ign_rk1", 4'd1, F1);
    read_chk("ign_rk10", 4'd10, F10);

    // Reset at T0+5 aborts expansion and clears everything.
    load_key(KeyF);
    for (int k = 0; k < 4; k++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", {127'h0, busy}, 128'h0);
    chk("abort_kv", {127'h0, keys_valid}, 128'h0);
    chk("abort_ready", {127'h0, key_ready}, 128'h1);
    for (int k = 0; k < 16; k++) begin
      read_chk($sformatf("abort_rk%0d", k), 4'(k), 128'h0);
    end

    // rst wins over a simultaneous key_valid.
    rst = 1'b1; key_valid = 1'b1; key_in = KeyF;
    tick();
    rst = 1'b0; key_valid = 1'b0;
    chk("rstkey_busy", {127'h0, busy}, 128'h0);
    read_chk("rstkey_rk0", 4'd0, 128'h0);

    // Reload from DONE: old entries stay visible until overwritten.
    load_key(KeyZ);
    wait_done("reload_z_lat");
    load_key(KeyF);
    chk("reload_kv_drop", {127'h0, keys_valid}, 128'h0);
    read_chk("reload_rk0", 4'd0, KeyF);
    read_chk("reload_old_rk10", 4'd10, Z10);
    wait_done("reload_f_lat");
    read_chk("reload_rk10", 4'd10, F10);
    read_chk("reload_rk13", 4'd13, 128'h0);

    // Back-to-back: key_valid held high from DONE.
    key_valid = 1'b1;
    key_in    = KeyF;
    for (int e = 1; e <= 40; e++) begin
      if (key_ready) acc_edges.push_back(e);
      tick();
    end
    key_valid = 1'b0;
    chk("b2b_count", 128'(acc_edges.size()), 128'd4);
    for (int j = 1; j < acc_edges.size(); j++) begin
      chk($sformatf("b2b_gap%0d", j), 128'(acc_edges[j] - acc_edges[j-1]), 128'd11);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
